dot_rect_layer_gen: RTL and testbench
=====================================

// Module: dot_rect_layer_gen
// PURPOSE
//  Multi-layer rectangle dot generator: N rectangles, each with its own colour and a fill/outline mode, shaded per pixel.
//  Rectangle registers are double-buffered (shadow/active) and swap on a frame commit, so CPU updates never tear mid-frame.
//  Sits in the VTUnit draw path ahead of the layer blender; fed by the display timing hpos/vpos counters.
//  Coordinates are signed, so off-screen rectangles still draw their visible part.
// PARAMETERS
//  pHdisplayWidth  11  width of iHpos; X coords are signed, pHdisplayWidth+1 bits
//  pVdisplayWidth  11  width of iVpos; Y coords are signed, pVdisplayWidth+1 bits
//  pColorDepth     16  pixel/colour width
//  pRectNum        4   rectangle count (1..16); index 0 = highest priority
//  pBorderWidth    4   outline thickness field width (thickness 1..2^pBorderWidth-1)
// PORTS
//  iClk        in   1      clock
//  iRst        in   1      synchronous reset, active-low
//  iHpos       in   pHdisplayWidth   current X (unsigned)
//  iVpos       in   pVdisplayWidth   current Y (unsigned)
//  iPosValid   in   1      hpos/vpos valid this cycle (active area)
//  iWe         in   1      write one shadow entry
//  iWSel       in   clog2(pRectNum)  entry select
//  iWLeftX/iWRightX  in  pHdisplayWidth+1 signed   X start (incl) / end (excl)
//  iWTopY/iWUnderY   in  pVdisplayWidth+1 signed   Y start (incl) / end (excl)
//  iWColor     in   pColorDepth      draw colour
//  iWMode      in   2      00 off, 01 fill, 10 outline, 11 reserved (= off)
//  iWBorder    in   pBorderWidth     outline thickness; 0 treated as 1
//  iCommit     in   1      one-cycle pulse (frame start): shadow -> active
//  oPixel      out  pColorDepth      pixel, 0 when no hit
//  oValid      out  1      oPixel valid (iPosValid delayed 2)
//  oHit        out  1      some rectangle hit
//  oHitIdx     out  clog2(pRectNum)  winning index, 0 when no hit
// BEHAVIOUR
//  - Reset (iRst=0 at a clock edge): all shadow and active modes = off, coords/colours = 0, pipeline cleared;
//    oPixel=0, oValid=0, oHit=0, oHitIdx=0. Reset mid-frame or mid-write discards that write.
//  - Write: iWe=1 updates shadow[iWSel] on the edge; iWSel >= pRectNum is ignored. The active set is unchanged.
//  - Commit: iCommit=1 copies every shadow entry into active on the edge. With iWe and iCommit in the same cycle,
//    active takes the pre-write shadow value; the write becomes visible at the next commit.
//  - Hit test per entry (active set), at pHdisplayWidth+2 / pVdisplayWidth+2 bits signed, so edges cannot overflow:
//    in  = L <= x < R && T <= y < U   (x,y zero-extended)
//    fill: hit = in.  outline (b = max(iWBorder,1)): hit = in && !(L+b <= x < R-b && T+b <= y < U-b).
//    Empty rect (L>=R or T>=U) never hits. When R-L <= 2b, outline degenerates to fill. off: never hits.
//  - Pipeline, latency 2, no stalls:
//    S1: register per-entry hit vector and iPosValid; the colour snapshot is taken from the active set.
//    S2: lowest-index hit wins -> oPixel=colour, oHit=1, oHitIdx=idx; no hit -> oPixel=0, oHit=0, oHitIdx=0.
//    oValid = iPosValid delayed 2. When iPosValid=0, S2 still evaluates but forces oPixel=0 and oHit=0.
//  - A commit on cycle t affects pixels sampled on cycle t+1 and later.
//    A pixel already in S1 keeps the colour it latched at S1, so no mixed-colour pixel is produced.
// STRUCTURE
//  - Package dot_rect_pkg: mode constants RECT_OFF/RECT_FILL/RECT_OUTLINE, localparam for the index width.
//  - Sub-module dot_rect_hit: combinational single-rectangle fill/outline test, instantiated pRectNum times
//    by generate. Shadow/active register arrays, commit logic, and the 2-stage priority mux live in the top.
// TESTING
//  1 Reset: hold iRst=0 3 cycles with iPosValid=1 -> oPixel=0, oValid=0, oHit=0. Release -> no hits without a commit.
//  2 Fill: rect0 L=10,R=20,T=5,U=8, colour 16'hF800, commit. Scan y=5 -> oPixel=F800 for x=10..19, 0 at x=9 and x=20,
//    with 2-cycle latency.
//  3 Off-screen: rect1 L=-5,R=3,T=-2,U=2, fill 16'h07E0 -> hit for x=0..2, y=0..1 only. Also check L=R=7 -> never hits.
//  4 Outline: rect2 L=0,R=10,T=0,U=10, border 2 -> y=4: hit at x=0,1,8,9 only. y=1: hit x=0..9. Set border 5 -> full fill.
//  5 Priority: rect0 and rect3 overlap at (12,6) -> oHitIdx=0 with rect0 colour. Set rect0 off and commit
//    -> oHitIdx=3 with rect3 colour.
//  6 Commit race: iWe(rect0 colour 16'h001F) and iCommit in the same cycle -> active still shows the old colour.
//    After the next commit -> 001F. Writes without a commit never change oPixel.

Source files
------------

// File: rtl/dot_rect_pkg.sv
// Shared constants for the rectangle dot generator: draw modes and index-width helper.
package dot_rect_pkg;

    localparam logic [1:0] RECT_OFF     = 2'b00;
    localparam logic [1:0] RECT_FILL    = 2'b01;
    localparam logic [1:0] RECT_OUTLINE = 2'b10;

    // A single rectangle still needs a one-bit select/index port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dot_rect_hit.sv
// Combinational fill/outline hit test of one pixel against one rectangle.
// Edges are compared two bits wider than the screen so L+b and R-b cannot wrap.
module dot_rect_hit
    import dot_rect_pkg::*;
#(
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pBorderWidth   = 4
)
(
    input  logic        [pHdisplayWidth-1:0] i_x,
    input  logic        [pVdisplayWidth-1:0] i_y,
    input  logic signed [pHdisplayWidth:0]   i_left,
    input  logic signed [pHdisplayWidth:0]   i_right,
    input  logic signed [pVdisplayWidth:0]   i_top,
    input  logic signed [pVdisplayWidth:0]   i_under,
    input  logic        [1:0]                i_mode,
    input  logic        [pBorderWidth-1:0]   i_border,
    output logic                             o_hit
);

    localparam int XW = pHdisplayWidth + 2;
    localparam int YW = pVdisplayWidth + 2;

    logic        [pBorderWidth-1:0] w_bnz;
    logic signed [XW-1:0]           w_x;
    logic signed [XW-1:0]           w_l;
    logic signed [XW-1:0]           w_r;
    logic signed [XW-1:0]           w_bx;
    logic signed [YW-1:0]           w_y;
    logic signed [YW-1:0]           w_t;
    logic signed [YW-1:0]           w_u;
    logic signed [YW-1:0]           w_by;
    logic                           w_in;
    logic                           w_inner;

    // Zero thickness behaves as a one-pixel outline.
    assign w_bnz = (i_border == '0) ? pBorderWidth'(1'b1) : i_border;

    assign w_x  = $signed({2'b00, i_x});
    assign w_y  = $signed({2'b00, i_y});
    assign w_l  = $signed({i_left[pHdisplayWidth], i_left});
    assign w_r  = $signed({i_right[pHdisplayWidth], i_right});
    assign w_t  = $signed({i_top[pVdisplayWidth], i_top});
    assign w_u  = $signed({i_under[pVdisplayWidth], i_under});
    assign w_bx = $signed({{(XW-pBorderWidth){1'b0}}, w_bnz});
    assign w_by = $signed({{(YW-pBorderWidth){1'b0}}, w_bnz});

    assign w_in    = (w_l <= w_x) && (w_x < w_r) && (w_t <= w_y) && (w_y < w_u);
    // An inner box that collapses to nothing turns the outline into a fill.
    assign w_inner = ((w_l + w_bx) <= w_x) && (w_x < (w_r - w_bx)) &&
                     ((w_t + w_by) <= w_y) && (w_y < (w_u - w_by));

    // Mode select; reserved encoding draws nothing.
    always_comb begin
        case (i_mode)
            RECT_FILL:    o_hit = w_in;
            RECT_OUTLINE: o_hit = w_in && !w_inner;
            default:      o_hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/dot_rect_layer_gen.sv
// Multi-layer rectangle dot generator with double-buffered rectangle registers
// and a two-stage hit/priority pipeline (index 0 wins).
module dot_rect_layer_gen
    import dot_rect_pkg::*;
#(
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pColorDepth    = 16,
    parameter int pRectNum       = 4,
    parameter int pBorderWidth   = 4
)
(
    input  logic                                iClk,
    input  logic                                iRst,
    input  logic        [pHdisplayWidth-1:0]    iHpos,
    input  logic        [pVdisplayWidth-1:0]    iVpos,
    input  logic                                iPosValid,
    input  logic                                iWe,
    input  logic        [idx_width(pRectNum)-1:0] iWSel,
    input  logic signed [pHdisplayWidth:0]      iWLeftX,
    input  logic signed [pHdisplayWidth:0]      iWRightX,
    input  logic signed [pVdisplayWidth:0]      iWTopY,
    input  logic signed [pVdisplayWidth:0]      iWUnderY,
    input  logic        [pColorDepth-1:0]       iWColor,
    input  logic        [1:0]                   iWMode,
    input  logic        [pBorderWidth-1:0]      iWBorder,
    input  logic                                iCommit,
    output logic        [pColorDepth-1:0]       oPixel,
    output logic                                oValid,
    output logic                                oHit,
    output logic        [idx_width(pRectNum)-1:0] oHitIdx
);

    localparam int IW = idx_width(pRectNum);

    logic signed [pHdisplayWidth:0]  r_sh_left   [pRectNum];
    logic signed [pHdisplayWidth:0]  r_sh_right  [pRectNum];
    logic signed [pVdisplayWidth:0]  r_sh_top    [pRectNum];
    logic signed [pVdisplayWidth:0]  r_sh_under  [pRectNum];
    logic        [pColorDepth-1:0]   r_sh_color  [pRectNum];
    logic        [1:0]               r_sh_mode   [pRectNum];
    logic        [pBorderWidth-1:0]  r_sh_border [pRectNum];

    logic signed [pHdisplayWidth:0]  r_ac_left   [pRectNum];
    logic signed [pHdisplayWidth:0]  r_ac_right  [pRectNum];
    logic signed [pVdisplayWidth:0]  r_ac_top    [pRectNum];
    logic signed [pVdisplayWidth:0]  r_ac_under  [pRectNum];
    logic        [pColorDepth-1:0]   r_ac_color  [pRectNum];
    logic        [1:0]               r_ac_mode   [pRectNum];
    logic        [pBorderWidth-1:0]  r_ac_border [pRectNum];

    logic        [pRectNum-1:0]      w_hit_vec;
    logic        [pRectNum-1:0]      r_hit_s1;
    logic                            r_val_s1;
    logic        [pColorDepth-1:0]   r_col_s1    [pRectNum];

    logic                            w_sel_hit;
    logic        [IW-1:0]            w_sel_idx;
    logic        [pColorDepth-1:0]   w_sel_col;

    // Shadow set: CPU writes land here; out-of-range selects are dropped.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            for (int i = 0; i < pRectNum; i++) begin
                r_sh_left[i]   <= '0;
                r_sh_right[i]  <= '0;
                r_sh_top[i]    <= '0;
                r_sh_under[i]  <= '0;
                r_sh_color[i]  <= '0;
                r_sh_mode[i]   <= RECT_OFF;
                r_sh_border[i] <= '0;
            end
        end else if (iWe && (int'(iWSel) < pRectNum)) begin
            r_sh_left[iWSel]   <= iWLeftX;
            r_sh_right[iWSel]  <= iWRightX;
            r_sh_top[iWSel]    <= iWTopY;
            r_sh_under[iWSel]  <= iWUnderY;
            r_sh_color[iWSel]  <= iWColor;
            r_sh_mode[iWSel]   <= iWMode;
            r_sh_border[iWSel] <= iWBorder;
        end else begin
            r_sh_mode[0] <= r_sh_mode[0];
        end
    end

    // Active set: whole-set copy on commit; a same-cycle write is not yet visible here.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            for (int i = 0; i < pRectNum; i++) begin
                r_ac_left[i]   <= '0;
                r_ac_right[i]  <= '0;
                r_ac_top[i]    <= '0;
                r_ac_under[i]  <= '0;
                r_ac_color[i]  <= '0;
                r_ac_mode[i]   <= RECT_OFF;
                r_ac_border[i] <= '0;
            end
        end else if (iCommit) begin
            for (int i = 0; i < pRectNum; i++) begin
                r_ac_left[i]   <= r_sh_left[i];
                r_ac_right[i]  <= r_sh_right[i];
                r_ac_top[i]    <= r_sh_top[i];
                r_ac_under[i]  <= r_sh_under[i];
                r_ac_color[i]  <= r_sh_color[i];
                r_ac_mode[i]   <= r_sh_mode[i];
                r_ac_border[i] <= r_sh_border[i];
            end
        end else begin
            r_ac_mode[0] <= r_ac_mode[0];
        end
    end

    for (genvar g = 0; g < pRectNum; g++) begin : g_hit
        dot_rect_hit #(
            .pHdisplayWidth (pHdisplayWidth),
            .pVdisplayWidth (pVdisplayWidth),
            .pBorderWidth   (pBorderWidth)
        ) u_hit (
            .i_x      (iHpos),
            .i_y      (iVpos),
            .i_left   (r_ac_left[g]),
            .i_right  (r_ac_right[g]),
            .i_top    (r_ac_top[g]),
            .i_under  (r_ac_under[g]),
            .i_mode   (r_ac_mode[g]),
            .i_border (r_ac_border[g]),
            .o_hit    (w_hit_vec[g])
        );
    end

    // Stage 1: hit vector plus a colour snapshot so a later commit cannot mix colours.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            r_hit_s1 <= '0;
            r_val_s1 <= 1'b0;
            for (int i = 0; i < pRectNum; i++) begin
                r_col_s1[i] <= '0;
            end
        end else begin
            r_hit_s1 <= w_hit_vec;
            r_val_s1 <= iPosValid;
            for (int i = 0; i < pRectNum; i++) begin
                r_col_s1[i] <= r_ac_color[i];
            end
        end
    end

    // Priority select: scanning downward lets the lowest hit index overwrite the rest.
    always_comb begin
        w_sel_hit = 1'b0;
        w_sel_idx = '0;
        w_sel_col = '0;
        for (int i = pRectNum - 1; i >= 0; i--) begin
            w_sel_hit = w_sel_hit | r_hit_s1[i];
            w_sel_idx = r_hit_s1[i] ? IW'(i) : w_sel_idx;
            w_sel_col = r_hit_s1[i] ? r_col_s1[i] : w_sel_col;
        end
    end

    // Stage 2: registered outputs, blanked outside the active area.
    always_ff @(posedge iClk) begin
        if (!iRst) begin
            oPixel  <= '0;
            oValid  <= 1'b0;
            oHit    <= 1'b0;
            oHitIdx <= '0;
        end else begin
            oValid  <= r_val_s1;
            oHit    <= r_val_s1 & w_sel_hit;
            oPixel  <= r_val_s1 ? w_sel_col : '0;
            oHitIdx <= (r_val_s1 && w_sel_hit) ? w_sel_idx : '0;
        end
    end

endmodule

// File: tb/tb_dot_rect_layer_gen.sv
// Bench for dot_rect_layer_gen: constant vector table, hand sequences and a random run
// checked every cycle against a behavioural shadow/active model.
module tb_dot_rect_layer_gen;

    logic               clk;
    logic               rst;
    logic [10:0]        hpos;
    logic [10:0]        vpos;
    logic               pv;
    logic               we;
    logic [1:0]         wsel;
    logic signed [11:0] wl, wr, wt, wu;
    logic [15:0]        wcol;
    logic [1:0]         wmode;
    logic [3:0]         wbord;
    logic               commit;
    logic [15:0]        opix;
    logic               oval;
    logic               ohit;
    logic [1:0]         oidx;

    dot_rect_layer_gen dut (
        .iClk(clk), .iRst(rst), .iHpos(hpos), .iVpos(vpos), .iPosValid(pv),
        .iWe(we), .iWSel(wsel), .iWLeftX(wl), .iWRightX(wr), .iWTopY(wt),
        .iWUnderY(wu), .iWColor(wcol), .iWMode(wmode), .iWBorder(wbord),
        .iCommit(commit), .oPixel(opix), .oValid(oval), .oHit(ohit), .oHitIdx(oidx)
    );

    always #5 clk = ~clk;

    typedef struct {int l; int r; int t; int u; int col; int mode; int bord;} ent_t;
    typedef struct {bit v; bit h; int idx; int pix;} exp_t;
    typedef struct {int ph; int x; int y; bit h; int idx; int pix;} vec_t;

    ent_t sh[4];
    ent_t ac[4];
    exp_t pexp;
    vec_t tbl[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(string nm, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic exp_t eval(int x, int y, bit v);
        exp_t e;
        e = '{v: v, h: 1'b0, idx: 0, pix: 0};
        if (v) begin
            for (int i = 3; i >= 0; i--) begin
                int b;
                bit inr, inner, hit;
                b = (ac[i].bord == 0) ? 1 : ac[i].bord;
                inr = (ac[i].l <= x) && (x < ac[i].r) && (ac[i].t <= y) && (y < ac[i].u);
                inner = (ac[i].l + b <= x) && (x < ac[i].r - b) &&
                        (ac[i].t + b <= y) && (y < ac[i].u - b);
                hit = (ac[i].mode == 1) ? inr : (ac[i].mode == 2) ? (inr && !inner) : 1'b0;
                if (hit) begin
                    e.h = 1'b1;
                    e.idx = i;
                    e.pix = ac[i].col;
                end
            end
        end
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 4; i++) begin
            sh[i] = '{0, 0, 0, 0, 0, 0, 0};
            ac[i] = '{0, 0, 0, 0, 0, 0, 0};
        end
    endtask

    // One clock: predict from the pre-edge active set, update the model, compare.
    task automatic tick();
        exp_t e, o;
        e = eval(int'(hpos), int'(vpos), pv);
        @(posedge clk);
        if (!rst) begin
            clear_model();
            o = '{0, 0, 0, 0};
            pexp = '{0, 0, 0, 0};
        end else begin
            if (commit) begin
                for (int i = 0; i < 4; i++) ac[i] = sh[i];
            end
            if (we) begin
                sh[wsel] = '{int'(wl), int'(wr), int'(wt), int'(wu), int'(wcol), int'(wmode), int'(wbord)};
            end
            o = pexp;
            pexp = e;
        end
        #1;
        chk("model_valid", int'(oval), int'(o.v));
        chk("model_hit", int'(ohit), int'(o.h));
        chk("model_pix", int'(opix), o.pix);
        if (o.v) chk("model_idx", int'(oidx), o.idx);
    endtask

    task automatic wr_ent(int sel, int l, int r, int t, int u, int col, int mode, int bord);
        we = 1'b1;
        wsel = 2'(sel);
        wl = 12'(l); wr = 12'(r); wt = 12'(t); wu = 12'(u);
        wcol = 16'(col); wmode = 2'(mode); wbord = 4'(bord);
        tick();
        we = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic probe(int x, int y);
        hpos = 11'(x);
        vpos = 11'(y);
        pv = 1'b1;
        tick();
        tick();
    endtask

    task automatic add(int ph, int x, int y, bit h, int idx, int pix);
        tbl.push_back('{ph, x, y, h, idx, pix});
    endtask

    task automatic configure(int ph);
        case (ph)
            1: begin
                wr_ent(0, 10, 20, 5, 8, 16'hF800, 1, 0);
                wr_ent(1, -5, 3, -2, 2, 16'h07E0, 1, 0);
            end
            2: begin
                wr_ent(1, 7, 7, 0, 10, 16'h07E0, 1, 0);
                wr_ent(2, 0, 10, 0, 10, 16'hAAAA, 2, 2);
            end
            3: wr_ent(2, 0, 10, 0, 10, 16'hAAAA, 2, 5);
            4: wr_ent(2, 0, 10, 0, 10, 16'hAAAA, 2, 0);
            5: wr_ent(3, 11, 14, 6, 7, 16'h1234, 1, 0);
            default: wr_ent(0, 10, 20, 5, 8, 16'hF800, 0, 0);
        endcase
        do_commit();
    endtask

    initial begin
        clk = 1'b0; rst = 1'b0; hpos = '0; vpos = '0; pv = 1'b0;
        we = 1'b0; wsel = '0; wl = '0; wr = '0; wt = '0; wu = '0;
        wcol = '0; wmode = '0; wbord = '0; commit = 1'b0;
        pexp = '{0, 0, 0, 0};
        clear_model();

        add(1, 9, 5, 0, 0, 0);        add(1, 10, 5, 1, 0, 16'hF800);
        add(1, 19, 5, 1, 0, 16'hF800); add(1, 20, 5, 0, 0, 0);
        add(1, 15, 7, 1, 0, 16'hF800); add(1, 15, 8, 0, 0, 0);
        add(1, 0, 0, 1, 1, 16'h07E0);  add(1, 2, 1, 1, 1, 16'h07E0);
        add(1, 3, 0, 0, 0, 0);         add(1, 0, 2, 0, 0, 0);
        add(2, 0, 4, 1, 2, 16'hAAAA);  add(2, 1, 4, 1, 2, 16'hAAAA);
        add(2, 2, 4, 0, 0, 0);         add(2, 7, 4, 0, 0, 0);
        add(2, 8, 4, 1, 2, 16'hAAAA);  add(2, 9, 4, 1, 2, 16'hAAAA);
        add(2, 10, 4, 0, 0, 0);        add(2, 5, 1, 1, 2, 16'hAAAA);
        add(2, 5, 8, 1, 2, 16'hAAAA);  add(2, 0, 0, 1, 2, 16'hAAAA);
        add(3, 5, 5, 1, 2, 16'hAAAA);  add(3, 4, 4, 1, 2, 16'hAAAA);
        add(3, 9, 9, 1, 2, 16'hAAAA);  add(3, 10, 9, 0, 0, 0);
        add(4, 0, 4, 1, 2, 16'hAAAA);  add(4, 1, 4, 0, 0, 0);
        add(4, 5, 9, 1, 2, 16'hAAAA);  add(4, 5, 8, 0, 0, 0);
        add(5, 12, 6, 1, 0, 16'hF800); add(5, 13, 6, 1, 0, 16'hF800);
        add(5, 12, 5, 1, 0, 16'hF800);
        add(6, 12, 6, 1, 3, 16'h1234); add(6, 11, 6, 1, 3, 16'h1234);
        add(6, 15, 6, 0, 0, 0);

        // Reset held with valid positions.
        pv = 1'b1; hpos = 11'd12; vpos = 11'd6;
        repeat (3) begin
            tick();
            chk("rst_pix", int'(opix), 0);
            chk("rst_valid", int'(oval), 0);
            chk("rst_hit", int'(ohit), 0);
        end
        rst = 1'b1;
        wr_ent(0, 0, 100, 0, 100, 16'hFFFF, 1, 0);
        for (int i = 0; i < 8; i++) begin
            hpos = 11'(i * 3);
            vpos = 11'(i);
            tick();
            chk("nocommit_hit", int'(ohit), 0);
        end

        for (int ph = 1; ph <= 6; ph++) begin
            configure(ph);
            foreach (tbl[k]) begin
                if (tbl[k].ph == ph) begin
                    probe(tbl[k].x, tbl[k].y);
                    chk($sformatf("tbl%0d_hit", k), int'(ohit), int'(tbl[k].h));
                    chk($sformatf("tbl%0d_pix", k), int'(opix), tbl[k].pix);
                    if (tbl[k].h) chk($sformatf("tbl%0d_idx", k), int'(oidx), tbl[k].idx);
                end
            end
        end

        // Write and commit in the same cycle.
        wr_ent(0, 10, 20, 5, 8, 16'hF800, 1, 0);
        do_commit();
        we = 1'b1; wsel = 2'd0; wl = 12'sd10; wr = 12'sd20; wt = 12'sd5; wu = 12'sd8;
        wcol = 16'h001F; wmode = 2'b01; wbord = 4'd0; commit = 1'b1;
        tick();
        we = 1'b0; commit = 1'b0;
        probe(15, 5);
        chk("race_old_pix", int'(opix), 16'hF800);
        do_commit();
        probe(15, 5);
        chk("race_new_pix", int'(opix), 16'h001F);
        wr_ent(0, 10, 20, 5, 8, 16'h5555, 1, 0);
        probe(15, 6);
        chk("nocommit_pix", int'(opix), 16'h001F);

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            pv = ($urandom_range(0, 3) != 0);
            hpos = 11'($urandom_range(0, 50));
            vpos = 11'($urandom_range(0, 50));
            we = ($urandom_range(0, 3) == 0);
            wsel = 2'($urandom_range(0, 3));
            wl = 12'(int'($urandom_range(0, 60)) - 20);
            wr = 12'(int'($urandom_range(0, 60)) - 10);
            wt = 12'(int'($urandom_range(0, 60)) - 20);
            wu = 12'(int'($urandom_range(0, 60)) - 10);
            wcol = 16'($urandom);
            wmode = 2'($urandom_range(0, 3));
            wbord = 4'($urandom_range(0, 15));
            commit = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst = 1'b1; we = 1'b0; commit = 1'b0;

        // Reset in the middle of a write and commit discards both.
        rst = 1'b0;
        we = 1'b1; wsel = 2'd0; wl = 12'sd0; wr = 12'sd100; wt = 12'sd0; wu = 12'sd100;
        wcol = 16'h7777; wmode = 2'b01; commit = 1'b1;
        tick();
        rst = 1'b1; we = 1'b0; commit = 1'b0;
        do_commit();
        probe(5, 5);
        chk("rst_discard_hit", int'(ohit), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
